// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes and datapath/register-file sizing.
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_NREGS = 32;
    localparam int ALU_AW    = $clog2(ALU_NREGS);

    typedef enum logic [2:0] {
        ALU_ADD = 3'd2,
        ALU_SUB = 3'd3,
        ALU_AND = 3'd4,
        ALU_OR  = 3'd5,
        ALU_NOR = 3'd6,
        ALU_XOR = 3'd7
    } alu_ctl_e;

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, r0 hard-wired to zero, synchronous clear on reset.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int NREGS = ALU_NREGS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] ra_addr,
    output logic [WIDTH-1:0]         ra_data,
    input  logic [$clog2(NREGS)-1:0] rb_addr,
    output logic [WIDTH-1:0]         rb_data,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata
);

    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0] regs [NREGS];

    // Register array update; a write to r0 is discarded so it always reads zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= {WIDTH{1'b0}};
            end
        end else if (we && (waddr != {AW{1'b0}})) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data = (ra_addr == {AW{1'b0}}) ? {WIDTH{1'b0}} : regs[ra_addr];
    assign rb_data = (rb_addr == {AW{1'b0}}) ? {WIDTH{1'b0}} : regs[rb_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage in front of the ALU: register read, immediate select and
// a one-deep output register. Optional write-to-read bypass: ALU_OPSTAGE_BYPASS_EN.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int NREGS = ALU_NREGS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(NREGS)-1:0] in_rs,
    input  logic [$clog2(NREGS)-1:0] in_rt,
    input  logic [$clog2(NREGS)-1:0] in_rd,
    input  logic [2:0]               in_control,
    input  logic                     in_use_imm,
    input  logic [WIDTH-1:0]         in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_A,
    output logic [WIDTH-1:0]         out_B,
    output logic [2:0]               out_control,
    output logic [$clog2(NREGS)-1:0] out_rd,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_addr,
    input  logic [WIDTH-1:0]         wb_data
);

    localparam int AW = $clog2(NREGS);

    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic             accept;

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .ra_addr (in_rs),
        .ra_data (rs_data),
        .rb_addr (in_rt),
        .rb_data (rt_data),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Operand selection; with bypass, a same-cycle writeback overrides the array read.
    always_comb begin
        a_sel = rs_data;
        b_sel = rt_data;
`ifdef ALU_OPSTAGE_BYPASS_EN
        if (wb_en && (wb_addr != {AW{1'b0}}) && (wb_addr == in_rs)) begin
            a_sel = wb_data;
        end else begin
            a_sel = rs_data;
        end
        if (in_use_imm) begin
            b_sel = in_imm;
        end else if (wb_en && (wb_addr != {AW{1'b0}}) && (wb_addr == in_rt)) begin
            b_sel = wb_data;
        end else begin
            b_sel = rt_data;
        end
`else
        if (in_use_imm) begin
            b_sel = in_imm;
        end else begin
            b_sel = rt_data;
        end
`endif
    end

    // Output register: captured only on accept, so held operands are snapshots.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_A       <= {WIDTH{1'b0}};
            out_B       <= {WIDTH{1'b0}};
            out_control <= 3'd0;
            out_rd      <= {AW{1'b0}};
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_A       <= a_sel;
            out_B       <= b_sel;
            out_control <= in_control;
            out_rd      <= in_rd;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus a
// randomized run against a behavioural model of the stage.
module tb_alu_operand_stage;
    import alu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [2:0]  in_control;
    logic        in_use_imm;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_A, out_B;
    logic [2:0]  out_control;
    logic [4:0]  out_rd;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_a, m_b;
    logic [2:0]  m_ctl;
    logic [4:0]  m_rd;

    always #5 clock = ~clock;

    alu_operand_stage dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_control  (in_control),
        .in_use_imm  (in_use_imm),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_A       (out_A),
        .out_B       (out_B),
        .out_control (out_control),
        .out_rd      (out_rd),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef ALU_OPSTAGE_BYPASS_EN
        if (wb_en && wb_addr == a) return wb_data;
`endif
        return m_regs[a];
    endfunction

    task automatic idle();
        reset = 1'b0; in_valid = 1'b0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0;
        in_control = 3'd0; in_use_imm = 1'b0; in_imm = 32'd0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [2:0] ctl);
        in_valid = 1'b1; in_rs = rs; in_rt = rt; in_rd = rd; in_control = ctl;
    endtask

    // Advance one clock edge and update the model from the inputs present at that edge.
    task automatic cycle();
        logic acc;
        @(posedge clock);
        acc = in_valid && (!m_valid || out_ready);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_valid = 1'b0; m_a = 32'd0; m_b = 32'd0; m_ctl = 3'd0; m_rd = 5'd0;
        end else begin
            if (acc) begin
                m_a = m_read(in_rs);
                m_b = in_use_imm ? in_imm : m_read(in_rt);
                m_ctl = in_control;
                m_rd = in_rd;
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
        end
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        idle();
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_A !== 32'd0) begin bad++; $display("FAIL reset_A got=%h exp=0", out_A); end
        total++; if (out_B !== 32'd0) begin bad++; $display("FAIL reset_B got=%h exp=0", out_B); end
        total++; if (out_control !== 3'd0 || out_rd !== 5'd0) begin
            bad++; $display("FAIL reset_ctl_rd got=%0d/%0d exp=0/0", out_control, out_rd); end
        cycle();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        write_reg(5'd5, 32'h0000_00FF);
        issue(5'd5, 5'd0, 5'd12, ALU_ADD);
        cycle();
        idle();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        total++; if (out_A !== 32'h0000_00FF) begin bad++; $display("FAIL basic_A got=%h exp=000000ff", out_A); end
        total++; if (out_B !== 32'd0) begin bad++; $display("FAIL basic_B got=%h exp=0", out_B); end
        total++; if (out_control !== 3'd2 || out_rd !== 5'd12) begin
            bad++; $display("FAIL basic_ctl_rd got=%0d/%0d exp=2/12", out_control, out_rd); end
        cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_r0();
        write_reg(5'd0, 32'hDEAD_BEEF);
        issue(5'd0, 5'd0, 5'd1, ALU_OR);
        cycle();
        idle();
        total++; if (out_A !== 32'd0 || out_B !== 32'd0) begin
            bad++; $display("FAIL r0_read got=%h/%h exp=0/0", out_A, out_B); end
        cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) write_reg(i[4:0], 32'h100 + i);
        issue(5'd1, 5'd0, 5'd1, ALU_SUB);
        out_ready = 1'b0;
        cycle();
        issue(5'd2, 5'd0, 5'd2, ALU_SUB);
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", k, in_ready); end
            cycle();
            total++; if (out_valid !== 1'b1 || out_A !== 32'h101 || out_rd !== 5'd1) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%0d exp=1/00000101/1", k, out_valid, out_A, out_rd); end
        end
        out_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            issue(i[4:0], 5'd0, i[4:0], ALU_SUB);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready op=%0d got=%b exp=1", i, in_ready); end
            cycle();
            total++; if (out_valid !== 1'b1 || out_A !== (32'h100 + i) || out_rd !== i[4:0]) begin
                bad++; $display("FAIL b2b_op op=%0d got=%b/%h/%0d exp=1/%h/%0d", i, out_valid, out_A, out_rd, 32'h100 + i, i); end
        end
        idle();
        cycle();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_same_cycle_wb();
        logic [31:0] exp_a;
`ifdef ALU_OPSTAGE_BYPASS_EN
        exp_a = 32'h0000_1234;
`else
        exp_a = 32'h0000_0001;
`endif
        write_reg(5'd7, 32'h1);
        issue(5'd7, 5'd7, 5'd3, ALU_XOR);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
        cycle();
        idle();
        total++; if (out_A !== exp_a || out_B !== exp_a) begin
            bad++; $display("FAIL same_cycle_wb got=%h/%h exp=%h", out_A, out_B, exp_a); end
        issue(5'd7, 5'd0, 5'd3, ALU_XOR);
        cycle();
        idle();
        total++; if (out_A !== 32'h1234) begin bad++; $display("FAIL wb_after got=%h exp=00001234", out_A); end
        cycle();
    endtask

    task automatic test_imm();
        write_reg(5'd9, 32'h55);
        issue(5'd0, 5'd9, 5'd4, ALU_AND);
        in_use_imm = 1'b1; in_imm = 32'hFFFF_FFFC;
        cycle();
        idle();
        total++; if (out_B !== 32'hFFFF_FFFC) begin bad++; $display("FAIL imm_B got=%h exp=fffffffc", out_B); end
        issue(5'd0, 5'd9, 5'd4, ALU_AND);
        cycle();
        idle();
        total++; if (out_B !== 32'h55) begin bad++; $display("FAIL reg_B got=%h exp=00000055", out_B); end
        cycle();
    endtask

    task automatic test_reset_mid();
        write_reg(5'd3, 32'h77);
        issue(5'd3, 5'd3, 5'd8, ALU_NOR);
        out_ready = 1'b0;
        cycle();
        reset = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h99;
        cycle();
        idle();
        total++; if (out_valid !== 1'b0 || out_A !== 32'd0) begin
            bad++; $display("FAIL reset_mid got=%b/%h exp=0/0", out_valid, out_A); end
        for (int i = 1; i < 10; i++) begin
            issue(i[4:0], i[4:0], 5'd1, ALU_ADD);
            cycle();
            total++; if (out_A !== 32'd0 || out_B !== 32'd0) begin
                bad++; $display("FAIL reset_clear r%0d got=%h/%h exp=0/0", i, out_A, out_B); end
        end
        idle();
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(99) == 0);
            in_valid   = ($urandom_range(3) != 0);
            in_rs      = 5'($urandom_range(7));
            in_rt      = 5'($urandom_range(7));
            in_rd      = 5'($urandom);
            in_control = 3'($urandom);
            in_use_imm = ($urandom_range(3) == 0);
            in_imm     = $urandom;
            out_ready  = ($urandom_range(2) != 0);
            wb_en      = ($urandom_range(1) == 0);
            wb_addr    = 5'($urandom_range(7));
            wb_data    = $urandom;
            #1;
            total++; if (in_ready !== (!m_valid || out_ready)) begin
                bad++; $display("FAIL rand_in_ready n=%0d got=%b exp=%b", n, in_ready, !m_valid || out_ready); end
            cycle();
            total++; if (out_valid !== m_valid || out_A !== m_a || out_B !== m_b ||
                         out_control !== m_ctl || out_rd !== m_rd) begin
                bad++; $display("FAIL rand_out n=%0d got=%b %h %h %0d %0d exp=%b %h %h %0d %0d", n,
                                out_valid, out_A, out_B, out_control, out_rd, m_valid, m_a, m_b, m_ctl, m_rd); end
        end
        idle();
        cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_r0();
        test_back_to_back();
        test_same_cycle_wb();
        test_imm();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch stage directly upstream of the 32-bit ALU. Holds the 32×32 architectural register file, accepts decoded ALU ops over a valid/ready handshake, and reads two source operands. It can substitute an immediate for B. It registers A, B, control and destination for one cycle in front of the ALU. The ALU result returns through the writeback port.

## Interface
- `WIDTH`, 32, datapath and register width.
- `NREGS`, 32, register count; address width is log2(NREGS).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  upstream op present.
- `in_ready`  out  1  stage can accept this cycle.
- `in_rs`, `in_rt`, `in_rd`  in  5 each  source A, source B, destination register.
- `in_control`  in  3  ALU control code, passed through untouched.
- `in_use_imm`  in  1  B comes from `in_imm` instead of `rt`.
- `in_imm`  in  WIDTH  pre-extended immediate.
- `out_valid`  out  1  operands presented to ALU.
- `out_ready`  in  1  downstream consumes this cycle.
- `out_A`, `out_B`  out  WIDTH  ALU operands.
- `out_control`  out  3  registered control code.
- `out_rd`  out  5  registered destination.
- `wb_en`  in  1  write ALU result.
- `wb_addr`  in  5  write address.
- `wb_data`  in  WIDTH  write data.

## Operation
- Register file: `r0` reads as 0 and ignores writes. Every other register is written on a clock edge when `wb_en` is high.
- `in_ready = !out_valid || out_ready`. This is combinational and is the only combinational input-to-output path.
- Accept = `in_valid && in_ready`. On accept, capture the following into the output register:
  - `out_A` = read(rs).
  - `out_B` = `in_use_imm` ? `in_imm` : read(rt).
  - `in_control` and `in_rd`.
- Output register is held stable while `out_valid && !out_ready`. Inputs are ignored while held.
- Valid update each edge:
  - accept → `out_valid`=1.
  - else `out_ready` → `out_valid`=0.
  - else hold.
- Simultaneous consume and accept gives back-to-back throughput of one op per cycle.
- Captured operands are snapshots. A writeback that lands after capture does not alter a held output.
- Writeback and accept in the same cycle:
  - The register write always occurs.
  - The operand value seen follows the Configuration rule.
- `wb_addr` = 0 with `wb_en`: no effect.

## Timing
- Reset, applied on a clock edge:
  - all registers set to 0.
  - `out_valid`=0.
  - `out_A`, `out_B`=0.
  - `out_control`=0.
  - `out_rd`=0.
- `in_ready`=1 the cycle after reset deasserts.
- Reset mid-operation discards the held op. `out_valid` is 0 after the edge regardless of `out_ready`. A writeback presented in the reset cycle is dropped.
- Latency: accept on edge N makes `out_valid` high after edge N, so operands are visible in cycle N+1.
- Writeback latency: written on edge N, readable by an op accepted on edge N+1 or later.
- No internal state machine beyond the single `out_valid` bit and the register array.

## Configuration
- `ALU_OPSTAGE_BYPASS_EN` defined: write-to-read bypass. On an accept cycle with `wb_en` and `wb_addr`==rs (or rt, when `!in_use_imm`), the captured operand is `wb_data`. The bypass never applies when the address is 0.
- Not defined: a same-cycle read returns the pre-write register value. Software or the scheduler must insert one bubble.

## Structure
- Shared package `alu_pkg` holds:
  - ALU control codes: ADD=3'd2, SUB=3'd3, AND=3'd4, OR=3'd5, NOR=3'd6, XOR=3'd7.
  - `WIDTH` and register-address width constants.
- This stage treats control as opaque.
- One sub-module: `alu_regfile`. It has 2 async read ports and 1 sync write port, with r0 forced to zero and a synchronous reset clear.
- Bypass muxing and the output register live in `alu_operand_stage`.

## Test plan
- Reset, then write r5=0x0000_00FF on edge 1. Accept rs=5, rt=0, control=ADD → `out_A`=0xFF, `out_B`=0, `out_control`=2, `out_valid`=1 one cycle later.
- Write r0=0xDEAD_BEEF, then issue rs=0 → `out_A`=0.
- Hold `out_ready`=0 for 3 cycles while `in_valid`=1 → `in_ready`=0, outputs stable. Release → next op issues the following cycle; no op lost or duplicated across 4 back-to-back ops.
- Same-cycle r7 write of 0x1234 with an issue of rs=7 (old r7=0x1):
  - `out_A`=0x1234 with `ALU_OPSTAGE_BYPASS_EN`.
  - `out_A`=0x1 without it.
  - Either way, r7 reads 0x1234 on the next issue.
- `in_use_imm`=1, `in_imm`=0xFFFF_FFFC, rt=9 holding 0x55 → `out_B`=0xFFFF_FFFC.
- Assert `reset` while `out_valid`=1 and `out_ready`=0 → `out_valid`=0 next cycle, all registers read 0.
